// File: rtl/fdtd_step_seq.sv
// fdtd_step_seq: FDTD coefficient register bank plus an autonomous timestep
// sequencer.
//
// The register port is word addressed. It is the same shape that the AXI word
// read/write adapters produce. Coefficients are byte-strobed and reach coef_o
// as soon as they are written. Once started, the sequencer walks the enabled
// update phases in index order, NSTEPS times. For each phase it emits a
// one-cycle start pulse and waits for that phase's end flag. Completion and a
// per-phase watchdog timeout raise int_pending, which drives irq_o when
// irq_en is set.
//
// Ports
//   ACLK, ARESET     clock, asynchronous active-high reset
//   reg_we_i/...     word write port (address, data, byte strobes)
//   reg_raddr_i      read address; reg_rdata_o is combinational
//   coef_o           COEF[k] at bits [k*DATA_WIDTH +: DATA_WIDTH]
//   phase_start_o    one-cycle start pulse per phase
//   phase_end_i      phase-done flags from the datapath
//   sample_i         observation-point value, latched at the end of each step
//   step_o           completed timesteps of the current/last run
//   busy_o, irq_o    sequencer active; interrupt request

// One byte-strobed coefficient word.
module fdtd_coef_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    we,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   q
);
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) q <= '0;
    else if (we)
      for (int b = 0; b < DATA_WIDTH/8; b++)
        if (wstrb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
  end
endmodule

module fdtd_step_seq #(
  parameter int DATA_WIDTH      = 32,
  parameter int WORD_ADDR_WIDTH = 8,
  parameter int N_COEF          = 8,
  parameter int N_PHASE         = 3,
  parameter int STEP_WIDTH      = 16,
  parameter int TIMEOUT_WIDTH   = 20
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         reg_we_i,
  input  logic [WORD_ADDR_WIDTH-1:0]   reg_waddr_i,
  input  logic [DATA_WIDTH-1:0]        reg_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]      reg_wstrb_i,
  input  logic [WORD_ADDR_WIDTH-1:0]   reg_raddr_i,
  output logic [DATA_WIDTH-1:0]        reg_rdata_o,
  output logic [N_COEF*DATA_WIDTH-1:0] coef_o,
  output logic [N_PHASE-1:0]           phase_start_o,
  input  logic [N_PHASE-1:0]           phase_end_i,
  input  logic [DATA_WIDTH-1:0]        sample_i,
  output logic [STEP_WIDTH-1:0]        step_o,
  output logic                         busy_o,
  output logic                         irq_o
);

  localparam logic [WORD_ADDR_WIDTH-1:0] A_CTRL    = WORD_ADDR_WIDTH'(8'h20);
  localparam logic [WORD_ADDR_WIDTH-1:0] A_NSTEPS  = WORD_ADDR_WIDTH'(8'h21);
  localparam logic [WORD_ADDR_WIDTH-1:0] A_MASK    = WORD_ADDR_WIDTH'(8'h22);
  localparam logic [WORD_ADDR_WIDTH-1:0] A_CMD     = WORD_ADDR_WIDTH'(8'h23);
  localparam logic [WORD_ADDR_WIDTH-1:0] A_STATUS  = WORD_ADDR_WIDTH'(8'h24);
  localparam logic [WORD_ADDR_WIDTH-1:0] A_STEP    = WORD_ADDR_WIDTH'(8'h25);
  localparam logic [WORD_ADDR_WIDTH-1:0] A_SAMPLE  = WORD_ADDR_WIDTH'(8'h26);
  localparam logic [WORD_ADDR_WIDTH-1:0] A_TIMEOUT = WORD_ADDR_WIDTH'(8'h27);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_NEXT, S_DONE} state_t;

  state_t                            state_q, state_d;
  logic [N_COEF-1:0][DATA_WIDTH-1:0] coef_q;
  logic [1:0]                        ctrl_q;         // {timeout_en, irq_en}
  logic [STEP_WIDTH-1:0]             nsteps_q, nsteps_snap, step_q;
  logic [N_PHASE-1:0]                mask_q, mask_snap;
  logic [TIMEOUT_WIDTH-1:0]          timeout_q, timer_q;
  logic [DATA_WIDTH-1:0]             sample_q;
  logic                              int_pending_q, timeout_err_q;
  logic [2:0]                        phase_q, phase_d;
  logic [7:0]                        end_vec;

  // Sequencer control strobes from the FSM
  logic snap, launch, step_inc, set_int, set_terr;
  logic [3:0] nxt_hi, first_snap, first_reg;       // {found, index}

  // Merge a write into an existing word under byte strobes
  function automatic logic [DATA_WIDTH-1:0] wmerge(
    input logic [DATA_WIDTH-1:0]   old_v,
    input logic [DATA_WIDTH-1:0]   new_v,
    input logic [DATA_WIDTH/8-1:0] strb
  );
    wmerge = old_v;
    for (int b = 0; b < DATA_WIDTH/8; b++)
      if (strb[b]) wmerge[b*8 +: 8] = new_v[b*8 +: 8];
  endfunction

  // Lowest enabled phase with index >= from
  function automatic logic [3:0] find_phase(input logic [N_PHASE-1:0] m, input int from);
    find_phase = 4'd0;
    for (int q = N_PHASE-1; q >= 0; q--)
      if (m[q] && q >= from) find_phase = {1'b1, 3'(q)};
  endfunction

  // Write decode
  logic wr_ctrl, wr_nsteps, wr_mask, wr_timeout, cmd_wr;
  logic cmd_start, cmd_abort, cmd_clr;

  assign wr_ctrl    = reg_we_i && reg_waddr_i == A_CTRL;
  assign wr_nsteps  = reg_we_i && reg_waddr_i == A_NSTEPS;
  assign wr_mask    = reg_we_i && reg_waddr_i == A_MASK;
  assign wr_timeout = reg_we_i && reg_waddr_i == A_TIMEOUT;
  assign cmd_wr     = reg_we_i && reg_waddr_i == A_CMD && reg_wstrb_i[0];
  assign cmd_start  = cmd_wr && reg_wdata_i[0];
  assign cmd_abort  = cmd_wr && reg_wdata_i[1];
  assign cmd_clr    = cmd_wr && reg_wdata_i[2];

  // Coefficient bank
  for (genvar k = 0; k < N_COEF; k++) begin : g_coef
    fdtd_coef_reg #(.DATA_WIDTH(DATA_WIDTH)) u_coef (
      .ACLK  (ACLK),
      .ARESET(ARESET),
      .we    (reg_we_i && reg_waddr_i == WORD_ADDR_WIDTH'(k)),
      .wdata (reg_wdata_i),
      .wstrb (reg_wstrb_i),
      .q     (coef_q[k])
    );
  end
  assign coef_o = coef_q;

  // Pad the end flags to 8 so the 3-bit phase index always selects in range
  assign end_vec    = 8'(phase_end_i);
  assign nxt_hi     = find_phase(mask_snap, int'(phase_q) + 1);
  assign first_snap = find_phase(mask_snap, 0);
  assign first_reg  = find_phase(mask_q, 0);

  // FSM state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and control strobes
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    snap     = 1'b0;
    launch   = 1'b0;
    step_inc = 1'b0;
    set_int  = 1'b0;
    set_terr = 1'b0;
    case (state_q)
      S_IDLE:
        if (cmd_start && !cmd_abort) begin
          if (nsteps_q != '0 && mask_q != '0) begin
            snap    = 1'b1;
            phase_d = first_reg[2:0];
            state_d = S_LAUNCH;
          end else begin
            set_int = 1'b1;
          end
        end
      S_LAUNCH: begin
        launch  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT:
        if (end_vec[phase_q]) begin
          state_d = S_NEXT;
        end else if (ctrl_q[1] && timeout_q != '0 && timer_q == timeout_q - 1'b1) begin
          set_terr = 1'b1;
          set_int  = 1'b1;
          state_d  = S_IDLE;
        end
      S_NEXT:
        if (nxt_hi[3]) begin
          phase_d = nxt_hi[2:0];
          state_d = S_LAUNCH;
        end else begin
          step_inc = 1'b1;
          if (STEP_WIDTH'(step_q + 1'b1) == nsteps_snap) begin
            state_d = S_DONE;
          end else begin
            phase_d = first_snap[2:0];
            state_d = S_LAUNCH;
          end
        end
      S_DONE: begin
        set_int = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort beats every transition, including a pending completion or timeout
    if (cmd_abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      phase_d  = phase_q;
      step_inc = 1'b0;
      set_int  = 1'b0;
      set_terr = 1'b0;
    end
  end

  // Registers and sequencer datapath
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ctrl_q        <= '0;
      nsteps_q      <= '0;
      mask_q        <= '0;
      timeout_q     <= '0;
      nsteps_snap   <= '0;
      mask_snap     <= '0;
      step_q        <= '0;
      sample_q      <= '0;
      timer_q       <= '0;
      phase_q       <= '0;
      int_pending_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      if (wr_ctrl)    ctrl_q    <= 2'(wmerge(DATA_WIDTH'(ctrl_q), reg_wdata_i, reg_wstrb_i));
      if (wr_nsteps)  nsteps_q  <= STEP_WIDTH'(wmerge(DATA_WIDTH'(nsteps_q), reg_wdata_i, reg_wstrb_i));
      if (wr_mask)    mask_q    <= N_PHASE'(wmerge(DATA_WIDTH'(mask_q), reg_wdata_i, reg_wstrb_i));
      if (wr_timeout) timeout_q <= TIMEOUT_WIDTH'(wmerge(DATA_WIDTH'(timeout_q), reg_wdata_i, reg_wstrb_i));

      if (snap) begin
        nsteps_snap   <= nsteps_q;
        mask_snap     <= mask_q;
        step_q        <= '0;
        timeout_err_q <= 1'b0;
      end
      if (step_inc) begin
        step_q   <= step_q + 1'b1;
        sample_q <= sample_i;
      end
      phase_q <= phase_d;

      if (launch)                 timer_q <= '0;
      else if (state_q == S_WAIT) timer_q <= timer_q + 1'b1;

      if (set_terr) timeout_err_q <= 1'b1;
      // A set event on the same edge beats clr_int
      if (set_int)      int_pending_q <= 1'b1;
      else if (cmd_clr) int_pending_q <= 1'b0;
    end
  end

  // Outputs
  assign busy_o = state_q != S_IDLE;
  assign irq_o  = int_pending_q & ctrl_q[0];
  assign step_o = step_q;

  always_comb begin
    phase_start_o = '0;
    if (state_q == S_LAUNCH)
      for (int p = 0; p < N_PHASE; p++) phase_start_o[p] = (phase_q == 3'(p));
  end

  // Read mux; CMD and unmapped addresses read 0
  always_comb begin
    reg_rdata_o = '0;
    for (int k = 0; k < N_COEF; k++)
      if (reg_raddr_i == WORD_ADDR_WIDTH'(k)) reg_rdata_o = coef_q[k];
    case (reg_raddr_i)
      A_CTRL:    reg_rdata_o = DATA_WIDTH'(ctrl_q);
      A_NSTEPS:  reg_rdata_o = DATA_WIDTH'(nsteps_q);
      A_MASK:    reg_rdata_o = DATA_WIDTH'(mask_q);
      A_STATUS: begin
        reg_rdata_o[0]    = busy_o;
        reg_rdata_o[1]    = int_pending_q;
        reg_rdata_o[2]    = timeout_err_q;
        // Phase index is only meaningful while a run is in flight
        reg_rdata_o[10:8] = busy_o ? phase_q : 3'd0;
      end
      A_STEP:    reg_rdata_o = DATA_WIDTH'(step_q);
      A_SAMPLE:  reg_rdata_o = sample_q;
      A_TIMEOUT: reg_rdata_o = DATA_WIDTH'(timeout_q);
      default: ;
    endcase
  end

endmodule

// File: doc/fdtd_step_seq.md
# fdtd_step_seq

Parametrised successor to the FDTD register controller. It holds N_COEF coefficient registers behind a word-level register port, the same port the AXI word read/write adapters produce. It also contains an autonomous timestep sequencer that walks the enabled update phases (Hy, Ez, source, …) for NSTEPS timesteps without CPU involvement. Per-phase start pulses and end flags connect to the FDTD datapath. Completion, abort and per-phase timeout are reported through STATUS and an interrupt.

## Interface
Parameters:
- DATA_WIDTH, 32, register and coefficient width (multiple of 8)
- WORD_ADDR_WIDTH, 8, register word address width
- N_COEF, 8, coefficient registers (≤ 32)
- N_PHASE, 3, update phases, index 0 first (≤ 8)
- STEP_WIDTH, 16, timestep counter width
- TIMEOUT_WIDTH, 20, per-phase watchdog width

Ports:
- ACLK  in  1  clock
- ARESET  in  1  reset; one clock, asynchronous active-high reset
- reg_we_i  in  1  register write strobe (one write per cycle)
- reg_waddr_i  in  WORD_ADDR_WIDTH  write word address
- reg_wdata_i  in  DATA_WIDTH  write data
- reg_wstrb_i  in  DATA_WIDTH/8  byte enables
- reg_raddr_i  in  WORD_ADDR_WIDTH  read word address
- reg_rdata_o  out  DATA_WIDTH  read data (combinational)
- coef_o  out  N_COEF*DATA_WIDTH  coefficients, COEF[k] at bits [k*DATA_WIDTH +: DATA_WIDTH]
- phase_start_o  out  N_PHASE  one-cycle start pulse per phase
- phase_end_i  in  N_PHASE  phase-done flag from datapath
- sample_i  in  DATA_WIDTH  observation-point value
- step_o  out  STEP_WIDTH  completed timesteps
- busy_o  out  1  sequencer active
- irq_o  out  1  int_pending & CTRL.irq_en

## Operation
Register map (word addresses):
- 0x00+k COEF[k]: RW, byte strobes.
- 0x20 CTRL: RW; bit0 irq_en, bit1 timeout_en.
- 0x21 NSTEPS: RW; STEP_WIDTH bits.
- 0x22 PHASE_MASK: RW; N_PHASE bits, bit p enables phase p.
- 0x23 CMD: write-only, reads 0; bit0 start, bit1 abort, bit2 clr_int.
- 0x24 STATUS: RO; bit0 busy, bit1 int_pending, bit2 timeout_err, bits[10:8] current phase index.
- 0x25 STEP: RO; equals step_o.
- 0x26 SAMPLE: RO; sample_i latched at end of each timestep.
- 0x27 TIMEOUT: RW; TIMEOUT_WIDTH bits, 0 = watchdog off.
- Unmapped addresses: read 0, writes ignored. Narrow registers are zero-extended on read.

General rules:
- All writes to RW registers take effect while busy. COEF changes are visible immediately.
- NSTEPS and PHASE_MASK are snapshotted at start. Later writes affect only the next run.

FSM states:
- IDLE: busy_o=0.
  - start with NSTEPS≠0 and PHASE_MASK≠0: snapshot; step←0; timeout_err←0; p←lowest enabled phase; go to LAUNCH.
  - start with NSTEPS=0 or PHASE_MASK=0: int_pending←1 and stay in IDLE.
- LAUNCH: phase_start_o[p]=1 for exactly this cycle; timer←0; go to WAIT.
- WAIT: timer increments each cycle.
  - phase_end_i[p]=1: go to NEXT.
  - Else if timeout_en, TIMEOUT≠0 and timer==TIMEOUT-1: timeout_err←1, int_pending←1, go to IDLE.
  - Only bit p of phase_end_i is sampled.
- NEXT:
  - If an enabled phase q>p exists: p←q, go to LAUNCH.
  - Otherwise the timestep is complete: step←step+1 (wraps at 2^STEP_WIDTH), SAMPLE←sample_i. If step+1==NSTEPS go to DONE, else p←lowest enabled phase and go to LAUNCH.
- DONE: int_pending←1; go to IDLE.

Commands and boundary cases:
- abort in any non-IDLE state: go to IDLE next cycle. No interrupt; step and SAMPLE are kept.
- abort and start in the same write: abort wins.
- start while busy: ignored.
- clr_int clears int_pending. If it coincides with a set event, the set wins.
- Reset mid-run: all state cleared immediately. No pulse is emitted after reset assertion.

## Timing
- Reset values: every register 0, coef_o 0, phase_start_o 0, busy_o 0, irq_o 0, step_o 0, FSM in IDLE.
- Register write: applied at the ACLK edge where reg_we_i=1.
- Read: reg_rdata_o is combinational on reg_raddr_i, 0-cycle latency.
- Run start: start written at edge E0 → LAUNCH in the cycle after E0, with phase_start_o high and busy_o=1.
- Phase handoff: phase_end_i[p] sampled at edge Ek → NEXT during cycle k+1 → next phase_start_o during cycle k+2.
- Interrupt: DONE cycle, then int_pending and irq_o set at the following edge. busy_o falls at the same edge.
- Minimum run length: 1 phase, 1 step, end returned the cycle after start → 4 cycles from start write to irq_o.
- Timeout: with TIMEOUT=T, timeout_err is set T cycles after the LAUNCH cycle.

## Test plan
- Reset then read 0x00–0x27 → all 0; irq_o=0, busy_o=0.
- Write COEF[2]=0x12345678, then wstrb=0b0010 data 0xAAAAAAAA → coef_o slice 2 = 0x1234AA78.
- NSTEPS=3, MASK=0b101, irq_en=1, datapath ends each phase 2 cycles after its start → start pulses in order 0,2,0,2,0,2; STEP=3; irq_o=1; STATUS=0x2; clr_int → irq_o=0.
- MASK=0b010, TIMEOUT=16, timeout_en=1, phase_end_i held 0 → STATUS bits[2:1]=11 sixteen cycles after the pulse; busy_o=0.
- NSTEPS=100, abort after 5 steps → busy_o=0 next cycle; STEP=5; irq_o=0; a second start restarts at step 0.
- Start with NSTEPS=0 → no phase pulses; int_pending=1 next cycle. Start while busy → no effect on sequence.
